// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned INST_W = 32;

  // Instruction word pushed for a misaligned fetch, which never reads memory.
  localparam logic [INST_W-1:0] FAULT_INST = 32'h0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic              fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// In-order synchronous FIFO of fetch entries. Clear beats push and pop;
// the head reads as all-zero while the FIFO is empty.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  fetch_entry_t      push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [CntW-1:0]   count,
  output fetch_entry_t      head,
  output logic              empty
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop, full;

  // Next-state for pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !clear;
    do_pop   = pop && !empty && !clear;
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head output, forced to zero when empty so reset shows clean outputs.
  always_comb begin
    count = count_q;
    head  = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Upstream credit accounting must never push into a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && !clear && full));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && !clear && empty));

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: accepts PC addresses, issues 1-cycle-latency memory
// reads, and queues {inst, pc, fault} in order for decode. Misaligned
// addresses bypass memory and travel as fault entries.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              inst_fault,
  input  logic              inst_ready,
  input  logic              flush
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned UseW = CntW + 1;

  logic            rs_valid_q, rs_valid_d;
  logic [31:0]     rs_pc_q, rs_pc_d;
  logic            rs_fault_q, rs_fault_d;

  logic            accept, aligned, pop, push;
  logic [UseW-1:0] credit_use;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Credit check counts the in-flight read so a push can never hit a full FIFO;
  // a same-cycle pop frees a slot, hence the inst_ready -> req_ready path.
  always_comb begin
    pop        = !fifo_empty && inst_ready;
    credit_use = UseW'(fifo_count) + UseW'(rs_valid_q) - UseW'(pop);
    req_ready  = !flush && (credit_use < UseW'(DEPTH));
    accept     = req_valid && req_ready;
    aligned    = (req_addr[1:0] == 2'b00);
    mem_req    = accept && aligned;
    mem_addr   = req_addr;
  end

  // Read-stage next state: capture the accepted PC and whether it faulted.
  always_comb begin
    rs_valid_d = accept;
    rs_pc_d    = rs_pc_q;
    rs_fault_d = rs_fault_q;
    if (accept) begin
      rs_pc_d    = req_addr;
      rs_fault_d = !aligned;
    end
  end

  // Read-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_valid_q <= 1'b0;
      rs_pc_q    <= '0;
      rs_fault_q <= 1'b0;
    end else begin
      rs_valid_q <= rs_valid_d;
      rs_pc_q    <= rs_pc_d;
      rs_fault_q <= rs_fault_d;
    end
  end

  // Returning data joins its PC; a flush drops the word arriving this cycle.
  always_comb begin
    push            = rs_valid_q && !flush;
    push_data.inst  = rs_fault_q ? FAULT_INST : mem_rdata;
    push_data.pc    = rs_pc_q;
    push_data.fault = rs_fault_q;
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (flush),
    .count     (fifo_count),
    .head      (head),
    .empty     (fifo_empty)
  );

  // Decode-facing head outputs.
  always_comb begin
    inst_valid = !fifo_empty;
    inst       = head.inst;
    inst_pc    = head.pc;
    inst_fault = head.fault;
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready = 1'b0;
  logic        flush = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  ifetch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .inst_ready (inst_ready),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
  endfunction

  // Instruction memory: fixed one-cycle read latency, garbage when not read.
  always @(posedge clk) mem_rdata <= mem_req ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of entries visible to decode plus one read in flight.
  fetch_entry_t exp_q[$];
  logic         pend_m = 1'b0;
  fetch_entry_t pend_e;

  function automatic logic model_ready();
    int used;
    used = exp_q.size() + int'(pend_m) - int'(exp_q.size() != 0 && inst_ready);
    return !flush && (used < int'(DEPTH));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_m = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      pend_m = 1'b0;
    end else begin
      logic acc;
      acc = req_valid && model_ready();
      if (exp_q.size() != 0 && inst_ready) void'(exp_q.pop_front());
      if (pend_m) exp_q.push_back(pend_e);
      pend_m = acc;
      if (acc) begin
        pend_e.fault = (req_addr[1:0] != 2'b00);
        pend_e.pc    = req_addr;
        pend_e.inst  = pend_e.fault ? 32'h0 : mem_word(req_addr);
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic rdy_e;
    rdy_e = model_ready();
    chk("req_ready", req_ready, rdy_e);
    chk("mem_req", mem_req, req_valid && rdy_e && (req_addr[1:0] == 2'b00));
    if (mem_req) chk("mem_addr", mem_addr, req_addr);
    chk("inst_valid", inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("inst", inst, exp_q[0].inst);
      chk("inst_pc", inst_pc, exp_q[0].pc);
      chk("inst_fault", inst_fault, exp_q[0].fault);
    end else if (!rst_n) begin
      chk("rst_inst", inst, 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("rst_fault", inst_fault, 1'b0);
    end
  end

  // Entries actually handed to decode, in order.
  fetch_entry_t popped[$];
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !flush) popped.push_back('{inst, inst_pc, inst_fault});
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic acc_now;
    logic [31:0] addr;
    logic [31:0] exp_pc[$];

    // Reset state
    #12;
    chk("reset_inst_valid", inst_valid, 1'b0);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_mem_req", mem_req, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    // Single request 0x100
    req_valid = 1'b1; req_addr = 32'h100;
    @(negedge clk);
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t1_not_yet", inst_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("t1_valid", inst_valid, 1'b1);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_pc", inst_pc, 32'h100);
    chk("t1_fault", inst_fault, 1'b0);
    next_cycle();
    inst_ready = 1'b1;
    idle(2);

    // Back-to-back with decode always ready
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      @(negedge clk);
      chk("b2b_ready", req_ready, 1'b1);
      next_cycle();
    end
    idle(4);
    chk("b2b_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("b2b_pc", popped[i].pc, 32'(i * 4));

    // Backpressure: credits cap accepts at DEPTH
    popped.delete();
    inst_ready = 1'b0;
    acc = 0; addr = 32'h200;
    for (int c = 0; c < 13; c++) begin
      inst_ready = (c == 8);
      req_valid = 1'b1; req_addr = addr;
      @(negedge clk);
      acc_now = req_valid && req_ready;
      if (c == 7) begin
        chk("bp_accepts", acc, 4);
        chk("bp_ready_low", req_ready, 1'b0);
      end
      next_cycle();
      if (acc_now) begin
        acc++;
        addr += 4;
      end
    end
    chk("bp_accepts_after_pop", acc, 5);
    inst_ready = 1'b1;
    idle(8);
    chk("bp_drain_count", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) chk("bp_pc", popped[i].pc, 32'h200 + 32'(i * 4));

    // Misaligned fetch in the middle
    popped.delete();
    req_valid = 1'b1; req_addr = 32'h0;
    next_cycle();
    req_addr = 32'h102;
    @(negedge clk);
    chk("mis_mem_req", mem_req, 1'b0);
    next_cycle();
    req_addr = 32'h4;
    next_cycle();
    idle(4);
    chk("mis_count", popped.size(), 3);
    exp_pc = '{32'h0, 32'h102, 32'h4};
    for (int i = 0; i < 3 && i < popped.size(); i++) chk("mis_pc", popped[i].pc, exp_pc[i]);
    if (popped.size() == 3) begin
      chk("mis_fault", popped[1].fault, 1'b1);
      chk("mis_inst", popped[1].inst, 32'h0);
      chk("mis_fault0", popped[0].fault, 1'b0);
    end

    // Flush with two buffered entries and 0x8 in flight
    popped.delete();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      next_cycle();
    end
    flush = 1'b1; req_addr = 32'h40;
    @(negedge clk);
    chk("fl_valid_before", inst_valid, 1'b1);
    chk("fl_ready", req_ready, 1'b0);
    next_cycle();
    flush = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    chk("fl_empty_after", inst_valid, 1'b0);
    next_cycle();
    idle(4);
    chk("fl_count", popped.size(), 1);
    if (popped.size() != 0) chk("fl_pc", popped[0].pc, 32'h40);

    // Asynchronous reset mid-stream
    popped.delete();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'h300 + 32'(i * 4);
      next_cycle();
    end
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_pc", inst_pc, 32'h0);
    chk("arst_fault", inst_fault, 1'b0);
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_ready", req_ready, 1'b1);
    next_cycle();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    idle(5);
    chk("arst_no_stale", popped.size(), 0);
    chk("arst_still_empty", inst_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the consumer of the PC register's fetch address. Accepts one address per cycle over a valid/ready handshake, issues aligned reads to a synchronous instruction memory with fixed 1-cycle read latency, and buffers returned words with their PC in an in-order FIFO. The decode stage pops the FIFO over a second valid/ready handshake; a redirect `flush` discards everything in flight.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  fetch address valid (from PC).
- `req_addr`  in  32  fetch address.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `mem_req`  out  1  memory read strobe.
- `mem_addr`  out  32  memory read address (word-aligned).
- `mem_rdata`  in  32  read data, valid the cycle after `mem_req`.
- `inst_valid`  out  1  FIFO head valid.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  head PC.
- `inst_fault`  out  1  head is a misaligned-fetch fault.
- `inst_ready`  in  1  decode pops head when high with `inst_valid`.
- `flush`  in  1  discard pending read and all FIFO contents.

## Operation
- Accept = `req_valid && req_ready`.
- `req_ready` = `!flush && (occ + pend - pop) < DEPTH`; `occ` = FIFO count, `pend` = read-stage valid (0/1), `pop` = `inst_valid && inst_ready`. Combinational path `inst_ready -> req_ready` is intentional.
- Aligned accept (`req_addr[1:0] == 0`): `mem_req=1`, `mem_addr=req_addr`; read stage captures {pc, fault=0}.
- Misaligned accept: `mem_req=0`; read stage captures {pc, fault=1}; entry pushed with `inst=0`. Order with neighbouring requests preserved.
- `mem_req=0` whenever no aligned accept; `mem_addr` then don't-care (drive `req_addr`).
- Read stage valid next cycle: push {`mem_rdata` or 0 if fault, pc, fault} into FIFO.
- Head outputs drive from FIFO read pointer; `inst_valid = occ != 0`.
- `flush`: at the next edge FIFO pointers/count and read-stage valid clear; the `mem_rdata` returning that cycle is dropped; no accept during `flush`. `flush` overrides simultaneous pop and push.
- Credit rule guarantees no push to a full FIFO; overflow is a design error (assertion).

## Timing
- Accept in cycle N -> `mem_req` in N -> data pushed at end of N+1 -> `inst_valid` in N+2. Fetch-to-decode latency 2 cycles.
- Sustained throughput 1 instr/cycle with `inst_ready` held high, for any `DEPTH >= 2`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Reset (async, any time, including mid-stream): FIFO empty, read stage invalid, pointers 0. Outputs during reset: `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_fault=0`, `mem_req=0`; `req_ready=1` (if `flush=0`). First accept possible in the first cycle after `rst_n` rises.

## Structure
- `ifetch_pkg`: `fetch_entry_t` struct {inst[31:0], pc[31:0], fault}, `INST_W=32`, `FAULT_INST=32'h0`.
- Sub-module `ifetch_fifo`: generic synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`, ports push/pop/clear/count/head. Async active-low reset.
- Top `ifetch`: credit logic, read stage register, memory drive, flush handling.

## Test plan
- Reset then single request `0x00000100` with `mem_rdata=0x00500093` -> `mem_req` same cycle, `inst_valid` two cycles later with `inst=0x00500093`, `inst_pc=0x100`, `inst_fault=0`.
- Back-to-back requests `0x0,0x4,0x8,0xC`, `inst_ready=1` -> four consecutive `inst_valid` cycles in order, `req_ready` never low.
- `inst_ready=0`, `DEPTH=4`, continuous requests -> exactly 4 accepts, then `req_ready=0`; one pop -> exactly one further accept; no entry lost or duplicated.
- Request `0x00000102` between `0x0` and `0x4` -> `mem_req=0` for it; output order `0x0`, `0x102` (`fault=1`, `inst=0`), `0x4`.
- `flush` in cycle after accept of `0x8` with 2 entries buffered -> next cycle `inst_valid=0`, `0x8` data dropped, `req_ready=0` during flush; new request `0x40` after flush returns only `0x40`.
- `rst_n` asserted low mid-stream with 3 entries and a pending read -> all outputs zero immediately, `req_ready=1`; after release no stale entry appears.
